// File: rtl/vend_pkg.sv
// Shared types for the coin vending datapath: coin encoding,
// controller state and the coin-to-value lookup.
package vend_pkg;

  localparam int VAL_W = 4;

  typedef enum logic [2:0] {
    NONE = 3'b000,
    CIRC = 3'b001,
    TRI  = 3'b011,
    PENT = 3'b101
  } coin_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DISP1,
    DISP2
  } state_t;

  function automatic logic [VAL_W-1:0] coin_value(coin_t c);
    case (c)
      CIRC:    coin_value = VAL_W'(1);
      TRI:     coin_value = VAL_W'(3);
      PENT:    coin_value = VAL_W'(5);
      default: coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/change_selector.sv
// Combinational change picker: finds at most two coins from the live
// inventory that sum exactly to i_change.
// Ports: i_change, i_pent/i_tri/i_circ counts in; o_first/o_second coins
// and o_ok (a solution exists) out.
module change_selector
  import vend_pkg::*;
#(
  parameter int INV_W    = 2,
  parameter int CREDIT_W = 4
) (
  input  logic [CREDIT_W-1:0] i_change,
  input  logic [INV_W-1:0]    i_pent,
  input  logic [INV_W-1:0]    i_tri,
  input  logic [INV_W-1:0]    i_circ,
  output coin_t               o_first,
  output coin_t               o_second,
  output logic                o_ok
);

  localparam coin_t COINS [3] = '{PENT, TRI, CIRC};

  logic [INV_W-1:0]  w_cnt [3];
  logic [CREDIT_W:0] w_val [3];
  logic [CREDIT_W:0] w_goal;

  assign w_cnt[0] = i_pent;
  assign w_cnt[1] = i_tri;
  assign w_cnt[2] = i_circ;
  assign w_goal   = {1'b0, i_change};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_val[i] = (CREDIT_W+1)'(coin_value(COINS[i]));
    end
  end

  // Single coins are preferred over pairs; within each group the
  // larger coin goes out first. A pair of one type needs two in stock.
  always_comb begin
    logic w_found;
    logic w_have;
    w_found  = 1'b0;
    w_have   = 1'b0;
    o_first  = NONE;
    o_second = NONE;
    for (int i = 0; i < 3; i++) begin
      if (!w_found && w_cnt[i] != '0 &&
          w_val[i] == w_goal) begin
        w_found = 1'b1;
        o_first = COINS[i];
      end
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = i; j < 3; j++) begin
        if (j != i) w_have = w_cnt[i] != '0 && w_cnt[j] != '0;
        else        w_have = w_cnt[i] > INV_W'(1);
        if (!w_found && w_have &&
            (w_val[i] + w_val[j]) == w_goal) begin
          w_found  = 1'b1;
          o_first  = COINS[i];
          o_second = COINS[j];
        end
      end
    end
    o_ok = w_found;
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Vending sequencer: credit accumulation, buy evaluation, and a two-coin
// valid/ready change dispenser that draws down the coin inventory.
// Ports: clock/reset; coin_valid/coin_type, cost/buy, restock + rs_* in;
// disp_valid/disp_coin/disp_ready handshake; credit, *_cnt, busy and
// status pulses/flags out.
module change_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int INV_W    = 2,
  parameter int CREDIT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [2:0]          coin_type,
  input  logic [CREDIT_W-1:0] cost,
  input  logic                buy,
  input  logic                restock,
  input  logic [INV_W-1:0]    rs_pent,
  input  logic [INV_W-1:0]    rs_tri,
  input  logic [INV_W-1:0]    rs_circ,
  input  logic                disp_ready,
  output logic                disp_valid,
  output logic [2:0]          disp_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic [INV_W-1:0]    pent_cnt,
  output logic [INV_W-1:0]    tri_cnt,
  output logic [INV_W-1:0]    circ_cnt,
  output logic                busy,
  output logic                coin_reject,
  output logic                sale_done,
  output logic                exact_amt,
  output logic                not_enough,
  output logic                cough_up
);

  state_t              r_state, w_next;
  logic [CREDIT_W-1:0] r_credit, r_cost;
  logic [INV_W-1:0]    r_pent, r_tri, r_circ;
  coin_t               r_first, r_second;
  logic                r_reject, r_sale;
  logic                r_exact, r_ne, r_cough;

  coin_t               w_sel_first, w_sel_second;
  logic                w_sel_ok;
  logic [CREDIT_W-1:0] w_change;
  logic [CREDIT_W:0]   w_sum;
  logic                w_idle, w_legal;
  logic                w_coin_ok, w_reject;
  logic                w_restock, w_take_buy;
  logic                w_hs;
  coin_t               w_disp_coin;
  logic [INV_W-1:0]    w_dec_cnt;
  logic                w_clr, w_sale, w_load;
  logic                w_set_ex, w_set_ne, w_set_cu;

  assign w_idle  = r_state == IDLE;
  assign w_legal = coin_type == CIRC ||
                   coin_type == TRI  ||
                   coin_type == PENT;
  assign w_sum   = {1'b0, r_credit} +
                   (CREDIT_W+1)'(coin_value(coin_t'(coin_type)));

  assign w_coin_ok = coin_valid && w_idle &&
                     w_legal && !w_sum[CREDIT_W];
  assign w_reject  = coin_valid && !w_coin_ok;
  assign w_restock = restock && w_idle;
  assign w_change  = r_credit - r_cost;

  change_selector #(
    .INV_W    (INV_W),
    .CREDIT_W (CREDIT_W)
  ) u_sel (
    .i_change (w_change),
    .i_pent   (r_pent),
    .i_tri    (r_tri),
    .i_circ   (r_circ),
    .o_first  (w_sel_first),
    .o_second (w_sel_second),
    .o_ok     (w_sel_ok)
  );

  assign disp_valid  = r_state == DISP1 || r_state == DISP2;
  assign w_disp_coin = (r_state == DISP1) ? r_first :
                       (r_state == DISP2) ? r_second : NONE;
  assign w_hs        = disp_valid && disp_ready;

  always_comb begin
    case (w_disp_coin)
      PENT:    w_dec_cnt = r_pent;
      TRI:     w_dec_cnt = r_tri;
      CIRC:    w_dec_cnt = r_circ;
      default: w_dec_cnt = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_take_buy = 1'b0;
    w_clr      = 1'b0;
    w_sale     = 1'b0;
    w_load     = 1'b0;
    w_set_ex   = 1'b0;
    w_set_ne   = 1'b0;
    w_set_cu   = 1'b0;
    case (r_state)
      IDLE: begin
        // restock takes priority; a coincident buy is dropped
        if (buy && !restock) begin
          w_take_buy = 1'b1;
          w_next     = EVAL;
        end
      end
      EVAL: begin
        w_next = IDLE;
        if (r_credit < r_cost) begin
          w_set_cu = 1'b1;
        end else if (r_credit == r_cost) begin
          w_set_ex = 1'b1;
          w_clr    = 1'b1;
          w_sale   = 1'b1;
        end else if (!w_sel_ok) begin
          w_set_ne = 1'b1;
        end else begin
          w_load = 1'b1;
          w_next = DISP1;
        end
      end
      DISP1: begin
        if (disp_ready) begin
          if (r_second != NONE) begin
            w_next = DISP2;
          end else begin
            w_clr  = 1'b1;
            w_sale = 1'b1;
            w_next = IDLE;
          end
        end
      end
      DISP2: begin
        if (disp_ready) begin
          w_clr  = 1'b1;
          w_sale = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_credit <= '0;
      r_cost   <= '0;
      r_pent   <= '0;
      r_tri    <= '0;
      r_circ   <= '0;
      r_first  <= NONE;
      r_second <= NONE;
      r_reject <= 1'b0;
      r_sale   <= 1'b0;
      r_exact  <= 1'b0;
      r_ne     <= 1'b0;
      r_cough  <= 1'b0;
    end else begin
      r_reject <= w_reject;
      r_sale   <= w_sale;
      // coin_ok only in IDLE, clear only outside it
      if (w_coin_ok)  r_credit <= w_sum[CREDIT_W-1:0];
      else if (w_clr) r_credit <= '0;
      if (w_take_buy) begin
        r_cost  <= cost;
        r_exact <= 1'b0;
        r_ne    <= 1'b0;
        r_cough <= 1'b0;
      end
      if (w_set_ex) r_exact <= 1'b1;
      if (w_set_ne) r_ne    <= 1'b1;
      if (w_set_cu) r_cough <= 1'b1;
      if (w_load) begin
        r_first  <= w_sel_first;
        r_second <= w_sel_second;
      end
      if (w_restock) begin
        r_pent <= rs_pent;
        r_tri  <= rs_tri;
        r_circ <= rs_circ;
      end else if (w_hs) begin
        case (w_disp_coin)
          PENT:    r_pent <= r_pent - INV_W'(1);
          TRI:     r_tri  <= r_tri  - INV_W'(1);
          CIRC:    r_circ <= r_circ - INV_W'(1);
          default: ;
        endcase
      end
    end
  end

  // The selector never picks an empty type, so a dispense can't underflow.
  a_no_underflow: assert property (
    @(posedge clock) disable iff (reset)
    w_hs |-> (w_dec_cnt != '0)
  );

  assign disp_coin   = w_disp_coin;
  assign credit      = r_credit;
  assign pent_cnt    = r_pent;
  assign tri_cnt     = r_tri;
  assign circ_cnt    = r_circ;
  assign busy        = !w_idle;
  assign coin_reject = r_reject;
  assign sale_done   = r_sale;
  assign exact_amt   = r_exact;
  assign not_enough  = r_ne;
  assign cough_up    = r_cough;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: one task per scenario,
// inline comparisons against hand-computed values.
module tb_change_dispense_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [2:0] coin_type = 3'b000;
  logic [3:0] cost = 4'd0;
  logic       buy = 1'b0;
  logic       restock = 1'b0;
  logic [1:0] rs_pent = 2'd0;
  logic [1:0] rs_tri = 2'd0;
  logic [1:0] rs_circ = 2'd0;
  logic       disp_ready = 1'b0;
  logic       disp_valid;
  logic [2:0] disp_coin;
  logic [3:0] credit;
  logic [1:0] pent_cnt, tri_cnt, circ_cnt;
  logic       busy, coin_reject, sale_done;
  logic       exact_amt, not_enough, cough_up;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_CIRC = 3'b001;
  localparam logic [2:0] C_TRI  = 3'b011;
  localparam logic [2:0] C_PENT = 3'b101;

  change_dispense_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .cost        (cost),
    .buy         (buy),
    .restock     (restock),
    .rs_pent     (rs_pent),
    .rs_tri      (rs_tri),
    .rs_circ     (rs_circ),
    .disp_ready  (disp_ready),
    .disp_valid  (disp_valid),
    .disp_coin   (disp_coin),
    .credit      (credit),
    .pent_cnt    (pent_cnt),
    .tri_cnt     (tri_cnt),
    .circ_cnt    (circ_cnt),
    .busy        (busy),
    .coin_reject (coin_reject),
    .sale_done   (sale_done),
    .exact_amt   (exact_amt),
    .not_enough  (not_enough),
    .cough_up    (cough_up)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic insert(input logic [2:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic do_restock(input logic [1:0] p,
                            input logic [1:0] t,
                            input logic [1:0] c);
    restock = 1'b1;
    rs_pent = p;
    rs_tri  = t;
    rs_circ = c;
    tick();
    restock = 1'b0;
  endtask

  task automatic do_buy(input logic [3:0] c);
    cost = c;
    buy  = 1'b1;
    tick();
    buy  = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    n_cmp++;
    if ({disp_valid, disp_coin, credit, busy} !== 9'd0) begin
      n_err++;
      $display("FAIL rst_out got %b want 0",
               {disp_valid, disp_coin, credit, busy});
    end
    n_cmp++;
    if ({pent_cnt, tri_cnt, circ_cnt} !== 6'd0) begin
      n_err++;
      $display("FAIL rst_cnt got %b want 0",
               {pent_cnt, tri_cnt, circ_cnt});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_change_sale();
    do_restock(2'd1, 2'd1, 2'd3);
    insert(C_PENT);
    insert(C_TRI);
    n_cmp++;
    if (credit !== 4'd8) begin
      n_err++;
      $display("FAIL t1_credit got %0d want 8", credit);
    end
    do_buy(4'd4);
    n_cmp++;
    if (busy !== 1'b1 || disp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL t1_eval got busy=%b dv=%b want 1 0",
               busy, disp_valid);
    end
    tick();
    n_cmp++;
    if (disp_valid !== 1'b1 || disp_coin !== C_TRI) begin
      n_err++;
      $display("FAIL t1_first got %b/%b want 1/011",
               disp_valid, disp_coin);
    end
    disp_ready = 1'b1;
    tick();
    n_cmp++;
    if (tri_cnt !== 2'd0 || disp_coin !== C_CIRC) begin
      n_err++;
      $display("FAIL t1_second got tri=%0d coin=%b want 0/001",
               tri_cnt, disp_coin);
    end
    tick();
    disp_ready = 1'b0;
    n_cmp++;
    if (circ_cnt !== 2'd2 || credit !== 4'd0 ||
        sale_done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t1_done got circ=%0d cr=%0d sd=%b bz=%b",
               circ_cnt, credit, sale_done, busy);
    end
    n_cmp++;
    if (exact_amt !== 1'b0 || pent_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL t1_flags got ex=%b pent=%0d want 0/1",
               exact_amt, pent_cnt);
    end
    tick();
    n_cmp++;
    if (sale_done !== 1'b0) begin
      n_err++;
      $display("FAIL t1_pulse got %b want 0", sale_done);
    end
  endtask

  task automatic test_cough_up();
    insert(C_TRI);
    do_buy(4'd5);
    tick();
    n_cmp++;
    if (cough_up !== 1'b1 || credit !== 4'd3 ||
        disp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t2 got cu=%b cr=%0d dv=%b bz=%b",
               cough_up, credit, disp_valid, busy);
    end
  endtask

  task automatic test_exact();
    insert(C_CIRC);
    insert(C_CIRC);
    do_buy(4'd5);
    n_cmp++;
    if (cough_up !== 1'b0) begin
      n_err++;
      $display("FAIL t3_clr got %b want 0", cough_up);
    end
    tick();
    n_cmp++;
    if (exact_amt !== 1'b1 || credit !== 4'd0 ||
        sale_done !== 1'b1) begin
      n_err++;
      $display("FAIL t3 got ex=%b cr=%0d sd=%b want 1/0/1",
               exact_amt, credit, sale_done);
    end
    n_cmp++;
    if ({pent_cnt, tri_cnt, circ_cnt} !== {2'd1, 2'd0, 2'd2}) begin
      n_err++;
      $display("FAIL t3_cnt got %0d/%0d/%0d want 1/0/2",
               pent_cnt, tri_cnt, circ_cnt);
    end
  endtask

  task automatic test_not_enough();
    do_restock(2'd0, 2'd0, 2'd1);
    insert(C_PENT);
    insert(C_TRI);
    insert(C_CIRC);
    do_buy(4'd5);
    tick();
    n_cmp++;
    if (not_enough !== 1'b1 || exact_amt !== 1'b0 ||
        credit !== 4'd9 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t4 got ne=%b ex=%b cr=%0d bz=%b",
               not_enough, exact_amt, credit, busy);
    end
    n_cmp++;
    if ({pent_cnt, tri_cnt, circ_cnt} !== {2'd0, 2'd0, 2'd1}) begin
      n_err++;
      $display("FAIL t4_cnt got %0d/%0d/%0d want 0/0/1",
               pent_cnt, tri_cnt, circ_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    do_restock(2'd3, 2'd3, 2'd3);
    insert(C_PENT);
    insert(C_PENT);
    do_buy(4'd2);
    tick();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (disp_valid !== 1'b1 || disp_coin !== C_PENT) begin
        n_err++;
        $display("FAIL t5_hold%0d got %b/%b want 1/101",
                 k, disp_valid, disp_coin);
      end
      tick();
    end
    coin_valid = 1'b1;
    coin_type  = C_CIRC;
    restock    = 1'b1;
    rs_pent    = 2'd1;
    rs_tri     = 2'd1;
    rs_circ    = 2'd1;
    tick();
    coin_valid = 1'b0;
    restock    = 1'b0;
    n_cmp++;
    if (coin_reject !== 1'b1 || credit !== 4'd10 ||
        pent_cnt !== 2'd3 || disp_coin !== C_PENT) begin
      n_err++;
      $display("FAIL t5_busy got rj=%b cr=%0d p=%0d c=%b",
               coin_reject, credit, pent_cnt, disp_coin);
    end
    disp_ready = 1'b1;
    tick();
    n_cmp++;
    if (pent_cnt !== 2'd2 || disp_coin !== C_TRI ||
        coin_reject !== 1'b0) begin
      n_err++;
      $display("FAIL t5_d2 got p=%0d c=%b rj=%b want 2/011/0",
               pent_cnt, disp_coin, coin_reject);
    end
    tick();
    disp_ready = 1'b0;
    n_cmp++;
    if (tri_cnt !== 2'd2 || credit !== 4'd0 ||
        sale_done !== 1'b1) begin
      n_err++;
      $display("FAIL t5_done got t=%0d cr=%0d sd=%b want 2/0/1",
               tri_cnt, credit, sale_done);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    insert(C_TRI);
    coin_valid = 1'b1;
    coin_type  = C_CIRC;
    cost       = 4'd4;
    buy        = 1'b1;
    tick();
    coin_valid = 1'b0;
    buy        = 1'b0;
    tick();
    n_cmp++;
    if (exact_amt !== 1'b1 || credit !== 4'd0 ||
        sale_done !== 1'b1) begin
      n_err++;
      $display("FAIL t7_coinbuy got ex=%b cr=%0d sd=%b",
               exact_amt, credit, sale_done);
    end
    insert(C_CIRC);
    restock = 1'b1;
    rs_pent = 2'd2;
    rs_tri  = 2'd2;
    rs_circ = 2'd2;
    cost    = 4'd1;
    buy     = 1'b1;
    tick();
    restock = 1'b0;
    buy     = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || pent_cnt !== 2'd2) begin
      n_err++;
      $display("FAIL t7_rsbuy got bz=%b p=%0d want 0/2",
               busy, pent_cnt);
    end
    tick();
    n_cmp++;
    if (sale_done !== 1'b0 || credit !== 4'd1 ||
        exact_amt !== 1'b1) begin
      n_err++;
      $display("FAIL t7_drop got sd=%b cr=%0d ex=%b",
               sale_done, credit, exact_amt);
    end
  endtask

  task automatic test_overflow_reset();
    do_reset();
    do_restock(2'd3, 2'd3, 2'd3);
    insert(C_PENT);
    insert(C_PENT);
    insert(C_TRI);
    insert(C_CIRC);
    insert(C_TRI);
    n_cmp++;
    if (coin_reject !== 1'b1 || credit !== 4'd14) begin
      n_err++;
      $display("FAIL t6_ovf got rj=%b cr=%0d want 1/14",
               coin_reject, credit);
    end
    insert(3'b010);
    n_cmp++;
    if (coin_reject !== 1'b1 || credit !== 4'd14) begin
      n_err++;
      $display("FAIL t6_illegal got rj=%b cr=%0d want 1/14",
               coin_reject, credit);
    end
    do_buy(4'd6);
    tick();
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    n_cmp++;
    if (disp_coin !== C_TRI || pent_cnt !== 2'd2) begin
      n_err++;
      $display("FAIL t6_d2 got c=%b p=%0d want 011/2",
               disp_coin, pent_cnt);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({disp_valid, disp_coin, credit, busy,
         pent_cnt, tri_cnt, circ_cnt} !== 15'd0) begin
      n_err++;
      $display("FAIL t6_rst got dv=%b c=%b cr=%0d bz=%b",
               disp_valid, disp_coin, credit, busy);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_change_sale();
    test_cough_up();
    test_exact();
    test_not_enough();
    test_stall();
    test_simultaneous();
    test_overflow_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
